// File: rtl/trap_ctrl.sv
// Trap controller: turns commit-stage exceptions, interrupts and MRET into CSR writes plus a fetch redirect.
// Latency: event accepted at t (flush/stall comb), CSR writes at t+1, redirect_valid from t+2.
// Backpressure: REDIRECT holds redirect_valid/redirect_pc until redirect_ready; stall stays high meanwhile.
// Optional feature: define TRAP_VECTORED_EN to vector interrupts to base + 4*code when csr_mtvec_mode == 1.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,

    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_tval,
    input  logic        mret,
    input  logic [2:0]  irq_pending,

    input  logic        csr_mie,
    input  logic        csr_mpie,
    input  logic [29:0] csr_mtvec_base,
    input  logic [1:0]  csr_mtvec_mode,
    input  logic [31:0] csr_mepc,

    output logic        mepc_wen,
    output logic [31:0] mepc_o,
    output logic        mcause_int_wen,
    output logic        mcause_int_o,
    output logic        mcause_code_wen,
    output logic [30:0] mcause_code_o,
    output logic        mtval_wen,
    output logic [31:0] mtval_o,
    output logic        mie_wen,
    output logic        mie_o,
    output logic        mpie_wen,
    output logic        mpie_o,

    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TRAP_WR  = 2'd1;
    localparam logic [1:0] ST_MRET_WR  = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;

    logic        irq_taken;
    logic [3:0]  irq_code;
    logic        accept_exc;
    logic        accept_irq;
    logic        accept_mret;
    logic        accept;
    logic [31:0] trap_base;
    logic [31:0] irq_target;

    // Values captured at acceptance and replayed in the write / redirect states.
    logic [31:0] cap_pc;
    logic        cap_int;
    logic [30:0] cap_code;
    logic [31:0] cap_tval;
    logic [31:0] cap_target;
    logic        cap_ie;

    logic        in_idle;
    logic        in_trap;
    logic        in_mret;
    logic        in_redir;

    assign in_idle  = (state == ST_IDLE);
    assign in_trap  = (state == ST_TRAP_WR);
    assign in_mret  = (state == ST_MRET_WR);
    assign in_redir = (state == ST_REDIRECT);

    assign trap_base = {csr_mtvec_base, 2'b00};

    // Event decode: exception beats interrupt beats MRET; interrupts ranked MEI > MSI > MTI.
    always_comb begin
        irq_taken = csr_mie && (irq_pending != 3'b000);
        irq_code  = 4'd7;
        if (irq_pending[2]) begin
            irq_code = 4'd11;
        end else if (irq_pending[0]) begin
            irq_code = 4'd3;
        end
        accept_exc  = in_idle && !rst && commit_valid && exc_valid;
        accept_irq  = in_idle && !rst && commit_valid && !exc_valid && irq_taken;
        accept_mret = in_idle && !rst && commit_valid && !exc_valid && !irq_taken && mret;
        accept      = accept_exc || accept_irq || accept_mret;
    end

`ifdef TRAP_VECTORED_EN
    // Vectored mode only moves interrupts; exceptions always land on the base.
    assign irq_target = (csr_mtvec_mode == 2'd1) ? (trap_base + {26'd0, irq_code, 2'b00})
                                                 : trap_base;
`else
    // Without vectoring every trap lands on the base; the mode field is don't-care.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_mode;
    assign irq_target        = trap_base;
`endif

    // Next-state logic; event inputs are only looked at from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_exc || accept_irq) begin
                    state_nxt = ST_TRAP_WR;
                end else if (accept_mret) begin
                    state_nxt = ST_MRET_WR;
                end
            end
            ST_TRAP_WR:  state_nxt = ST_REDIRECT;
            ST_MRET_WR:  state_nxt = ST_REDIRECT;
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight trap including a pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture PC, cause, tval, target and the interrupt-enable bit to save, on acceptance only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pc     <= 32'd0;
            cap_int    <= 1'b0;
            cap_code   <= 31'd0;
            cap_tval   <= 32'd0;
            cap_target <= 32'd0;
            cap_ie     <= 1'b0;
        end else if (accept) begin
            cap_pc <= commit_pc;
            if (accept_exc) begin
                cap_int    <= 1'b0;
                cap_code   <= {27'd0, exc_code};
                cap_tval   <= exc_tval;
                cap_target <= trap_base;
                cap_ie     <= csr_mie;
            end else if (accept_irq) begin
                cap_int    <= 1'b1;
                cap_code   <= {27'd0, irq_code};
                cap_tval   <= 32'd0;
                cap_target <= irq_target;
                cap_ie     <= csr_mie;
            end else begin
                cap_int    <= 1'b0;
                cap_code   <= 31'd0;
                cap_tval   <= 32'd0;
                cap_target <= csr_mepc;
                cap_ie     <= csr_mpie;
            end
        end
    end

    // CSR write port: data is forced to zero whenever its enable is low.
    assign mepc_wen        = in_trap;
    assign mepc_o          = in_trap ? cap_pc : 32'd0;
    assign mcause_int_wen  = in_trap;
    assign mcause_int_o    = in_trap & cap_int;
    assign mcause_code_wen = in_trap;
    assign mcause_code_o   = in_trap ? cap_code : 31'd0;
    assign mtval_wen       = in_trap;
    assign mtval_o         = in_trap ? cap_tval : 32'd0;
    assign mie_wen         = in_trap | in_mret;
    assign mie_o           = in_mret & cap_ie;
    assign mpie_wen        = in_trap | in_mret;
    assign mpie_o          = in_trap ? cap_ie : in_mret;

    // Pipeline control and fetch redirect.
    assign flush          = accept;
    assign stall          = accept | !in_idle;
    assign redirect_valid = in_redir;
    assign redirect_pc    = in_redir ? cap_target : 32'd0;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: commit_valid  in  1  instruction at commit stage; commit_pc  in  32  its PC.
REQ-003 SHALL have: exc_valid  in  1  commit instruction faults; exc_code  in  4  exception code; exc_tval  in  32  fault value.
REQ-004 SHALL have: mret  in  1  commit instruction is MRET; irq_pending  in  3  [0]=MSI, [1]=MTI, [2]=MEI.
REQ-005 SHALL have CSR inputs: csr_mie, csr_mpie  in  1 each; csr_mtvec_base  in  30; csr_mtvec_mode  in  2; csr_mepc  in  32.
REQ-006 SHALL have CSR write outputs, each with a 1-bit _wen: mepc_o  32; mcause_int_o  1; mcause_code_o  31; mtval_o  32; mie_o  1; mpie_o  1.
REQ-007 SHALL have: flush  out  1  kill younger instructions; stall  out  1  freeze commit stage; redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1  fetch accepts redirect.

Function
REQ-008 SHALL implement the FSM IDLE, TRAP_WR, MRET_WR, REDIRECT.
REQ-009 SHALL accept an event only in IDLE with commit_valid=1, using priority exception > interrupt > mret.
REQ-010 SHALL treat an interrupt as taken when csr_mie=1 and irq_pending!=0, using priority MEI(11) > MSI(3) > MTI(7).
REQ-011 SHALL, in the acceptance cycle, assert flush and stall combinationally and capture the PC, cause, tval and target into registers.
REQ-012 SHALL, in TRAP_WR (exactly one cycle), assert all six wens with mepc_o=commit_pc, mcause_int_o/mcause_code_o=cause, mie_o=0, mpie_o=csr_mie.
REQ-013 SHALL set mtval_o=exc_tval for exceptions and mtval_o=0 for interrupts.
REQ-014 SHALL, in MRET_WR (one cycle), assert only mie_wen and mpie_wen, with mie_o=csr_mpie, mpie_o=1, and set the target to csr_mepc.
REQ-015 SHALL set the trap target to {csr_mtvec_base,2'b00}.
REQ-016 SHALL, in REDIRECT, hold redirect_valid=1 and redirect_pc stable until redirect_ready=1, then return to IDLE on the next cycle.
REQ-017 SHALL keep stall=1 in every non-IDLE state and ignore all event inputs there.
REQ-018 SHALL give a latency of acceptance at t, CSR writes at t+1, and redirect_valid at t+2 at the earliest.
REQ-019 SHALL handle exc_valid and mret asserted together as an exception, with the MRET discarded.
REQ-020 SHALL hold every wen at 0 outside TRAP_WR and MRET_WR.

Reset
REQ-021 SHALL, on rst, return to IDLE from any state, including mid-REDIRECT, and drop the pending redirect.
REQ-022 SHALL drive all outputs to 0 (wens, flush, stall, redirect_valid, redirect_pc, data outputs) in the cycle after rst.

Configuration
REQ-023 SHALL, when TRAP_VECTORED_EN is defined and csr_mtvec_mode=1, set the interrupt target to {csr_mtvec_base,2'b00}+4*code; exceptions SHALL still use the base.
REQ-024 SHALL, without TRAP_VECTORED_EN, ignore csr_mtvec_mode and use the base for all traps.

Verification
REQ-025 SHALL cover: exc_valid, exc_code=2, commit_pc=0x100, tval=0xDEAD, mtvec=0x8000 -> t+1 mepc=0x100, mcause=2, mtval=0xDEAD, mie_o=0; t+2 redirect_pc=0x8000.
REQ-026 SHALL cover: irq_pending=3'b111, csr_mie=1 -> mcause_int_o=1, code=11; with csr_mie=0 -> no acceptance.
REQ-027 SHALL cover: mret, csr_mepc=0x204, csr_mpie=1 -> mie_o=1, mpie_o=1, redirect_pc=0x204, mtval_wen=0.
REQ-028 SHALL cover: redirect_ready held low 5 cycles -> redirect_valid and redirect_pc stable; exit one cycle after ready.
REQ-029 SHALL cover: rst asserted in REDIRECT -> next cycle redirect_valid=0, stall=0, state IDLE.
REQ-030 SHALL cover: TRAP_VECTORED_EN, mode=1, base=0x2000 (byte 0x8000), MTI -> redirect_pc=0x801C; exception -> 0x8000.
